// File: rtl/ac97_cmd_scheduler.sv
// rtl/ac97_cmd_scheduler.sv - AC97 codec register-write scheduler (init ROM + CPU request arbitration)
// Issues at most one slot-1/2 command per frame, held stable until the next frame edge.
module ac97_cmd_scheduler #(
   parameter int WAIT_FRAMES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_start,
   input  logic        codec_ready,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [6:0]  req_addr,
   input  logic [15:0] req_data,
   output logic        cmd_valid,
   output logic [6:0]  cmd_addr,
   output logic [15:0] cmd_data,
   output logic        init_done,
   output logic [7:0]  issued_count
);

   localparam int CNT_W = (WAIT_FRAMES < 1) ? 1 : $clog2(WAIT_FRAMES + 1);

   typedef enum logic [1:0] {
      S_WAIT_READY,
      S_SETTLE,
      S_INIT,
      S_RUN
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] settle_q, settle_d;
   logic [1:0]       rom_idx_q, rom_idx_d;
   logic             pending_q, pending_d;
   logic [6:0]       pend_addr_q, pend_addr_d;
   logic [15:0]      pend_data_q, pend_data_d;
   logic             cmd_valid_q, cmd_valid_d;
   logic [6:0]       cmd_addr_q, cmd_addr_d;
   logic [15:0]      cmd_data_q, cmd_data_d;
   logic             init_done_q, init_done_d;
   logic [7:0]       count_q, count_d;
   logic [6:0]       rom_addr;
   logic [15:0]      rom_data;

   always_comb begin
      rom_addr = 7'h00;
      rom_data = 16'h0000;
      case (rom_idx_q)
         2'd0: begin rom_addr = 7'h02; rom_data = 16'h0000; end
         2'd1: begin rom_addr = 7'h04; rom_data = 16'h0000; end
         2'd2: begin rom_addr = 7'h18; rom_data = 16'h0808; end
         default: begin rom_addr = 7'h2C; rom_data = 16'hBB80; end
      endcase
   end

   always_comb begin
      state_d     = state_q;
      settle_d    = settle_q;
      rom_idx_d   = rom_idx_q;
      pending_d   = pending_q;
      pend_addr_d = pend_addr_q;
      pend_data_d = pend_data_q;
      cmd_valid_d = cmd_valid_q;
      cmd_addr_d  = cmd_addr_q;
      cmd_data_d  = cmd_data_q;
      init_done_d = init_done_q;
      count_d     = count_q;
      req_ready   = init_done_q & ~pending_q;

      // Capture needs pending clear, issue needs it set, so they never collide.
      if (req_valid && req_ready) begin
         pend_addr_d = req_addr;
         pend_data_d = req_data;
         pending_d   = 1'b1;
      end

      if (frame_start) begin
         cmd_valid_d = 1'b0;
         if (state_q == S_WAIT_READY) begin
            if (codec_ready) begin
               state_d  = S_SETTLE;
               settle_d = '0;
            end
         end else if (!codec_ready) begin
            state_d     = S_WAIT_READY;
            init_done_d = 1'b0;
            rom_idx_d   = 2'd0;
         end else begin
            case (state_q)
               S_SETTLE: begin
                  if (settle_q == CNT_W'(WAIT_FRAMES)) begin
                     cmd_valid_d = 1'b1;
                     cmd_addr_d  = rom_addr;
                     cmd_data_d  = rom_data;
                     count_d     = count_q + 8'd1;
                     rom_idx_d   = rom_idx_q + 2'd1;
                     state_d     = S_INIT;
                  end else begin
                     settle_d = settle_q + CNT_W'(1);
                  end
               end
               S_INIT: begin
                  cmd_valid_d = 1'b1;
                  cmd_addr_d  = rom_addr;
                  cmd_data_d  = rom_data;
                  count_d     = count_q + 8'd1;
                  rom_idx_d   = rom_idx_q + 2'd1;
                  if (rom_idx_q == 2'd3) begin
                     init_done_d = 1'b1;
                     state_d     = S_RUN;
                  end
               end
               S_RUN: begin
                  if (pending_q) begin
                     cmd_valid_d = 1'b1;
                     cmd_addr_d  = pend_addr_q;
                     cmd_data_d  = pend_data_q;
                     count_d     = count_q + 8'd1;
                     pending_d   = 1'b0;
                  end
               end
               default: state_d = S_WAIT_READY;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_WAIT_READY;
         settle_q    <= '0;
         rom_idx_q   <= 2'd0;
         pending_q   <= 1'b0;
         pend_addr_q <= 7'h00;
         pend_data_q <= 16'h0000;
         cmd_valid_q <= 1'b0;
         cmd_addr_q  <= 7'h00;
         cmd_data_q  <= 16'h0000;
         init_done_q <= 1'b0;
         count_q     <= 8'h00;
      end else begin
         state_q     <= state_d;
         settle_q    <= settle_d;
         rom_idx_q   <= rom_idx_d;
         pending_q   <= pending_d;
         pend_addr_q <= pend_addr_d;
         pend_data_q <= pend_data_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_addr_q  <= cmd_addr_d;
         cmd_data_q  <= cmd_data_d;
         init_done_q <= init_done_d;
         count_q     <= count_d;
      end
   end

   assign cmd_valid    = cmd_valid_q;
   assign cmd_addr     = cmd_addr_q;
   assign cmd_data     = cmd_data_q;
   assign init_done    = init_done_q;
   assign issued_count = count_q;

endmodule
